// File: rtl/branch_resolve_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_pkg
// Shared definitions for the branch resolve unit slice: default queue depth
// and counter width, the delay-slot offset used for not-taken redirects, and
// the layout of one in-flight branch entry.
// -----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

    localparam int QDEPTH_DEF = 4;
    localparam int CNT_W_DEF  = 32;

    // A not-taken branch falls through past its delay slot.
    localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

    typedef struct packed {
        logic [31:0] pc;
        logic        predTake;
    } branchEntry_t;

    // Fall-through fetch address; wraps modulo 2^32.
    function automatic logic [31:0] fallThroughPc(input logic [31:0] pc);
        return pc + DELAY_SLOT_OFFSET;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_if
// Bundles the pipeline-facing signals of the branch resolve unit.
//   D stage  : branchD, pred_takeD, pcD, stallD, flushD      (pipeline -> unit)
//   E stage  : resolve_validE, actual_takeE, targetE          (pipeline -> unit)
//   Redirect : mispredict, redirect_pc, stall_req             (unit -> pipeline)
//   Update   : branchM, actual_takeM, pcM                     (unit -> predictor)
//   Status   : branch_cnt, mispred_cnt, q_err                 (unit -> pipeline)
// The master modport is the pipeline side, the slave modport is the unit.
// -----------------------------------------------------------------------------
interface branch_resolve_unit_if
    import branch_resolve_unit_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
)
();

    logic             branchD;
    logic             pred_takeD;
    logic [31:0]      pcD;
    logic             stallD;
    logic             flushD;
    logic             resolve_validE;
    logic             actual_takeE;
    logic [31:0]      targetE;
    logic             mispredict;
    logic [31:0]      redirect_pc;
    logic             stall_req;
    logic             branchM;
    logic             actual_takeM;
    logic [31:0]      pcM;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;
    logic             q_err;

    modport master (
        output branchD, pred_takeD, pcD, stallD, flushD,
        output resolve_validE, actual_takeE, targetE,
        input  mispredict, redirect_pc, stall_req,
        input  branchM, actual_takeM, pcM,
        input  branch_cnt, mispred_cnt, q_err
    );

    modport slave (
        input  branchD, pred_takeD, pcD, stallD, flushD,
        input  resolve_validE, actual_takeE, targetE,
        output mispredict, redirect_pc, stall_req,
        output branchM, actual_takeM, pcM,
        output branch_cnt, mispred_cnt, q_err
    );

endinterface

// File: rtl/branch_resolve_unit_branch_info_fifo.sv
// -----------------------------------------------------------------------------
// branch_info_fifo
// Synchronous circular FIFO of in-flight branch entries.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : drop every entry after this cycle's pop
//   push      : write pushData at the tail (caller guarantees room)
//   pop       : retire the head entry (caller guarantees non-empty)
//   full/empty: occupancy flags
//   head      : oldest entry, valid whenever empty is low
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module branch_info_fifo
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = QDEPTH_DEF
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  branchEntry_t pushData,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output branchEntry_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [AW:0] PTR_ONE = PW'(1);

    logic [AW:0]  wrPtr;
    logic [AW:0]  rdPtr;
    logic [AW:0]  rdNext;
    branchEntry_t mem [DEPTH];

    assign rdNext = pop ? rdPtr + PTR_ONE : rdPtr;
    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign head   = mem[rdPtr[AW-1:0]];

    // Pointer update. A clear collapses the queue onto the post-pop read
    // pointer, so anything written this cycle is discarded with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            rdPtr <= rdNext;
            if (clear) begin
                wrPtr <= rdNext;
            end else if (push) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
        end
    end

    // Entry storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr[AW-1:0]] <= pushData;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Tracks branches predicted in D, resolves them in order against the E-stage
// outcome, raises a registered mispredict/redirect, feeds the outcome back to
// the predictor one cycle later and keeps saturating accuracy counters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : branch_resolve_unit_if slave (D inputs, E inputs, redirect,
//              predictor update, counters and sticky queue error)
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
)
(
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_unit_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    branchEntry_t     head;
    branchEntry_t     newEntry;
    logic             full;
    logic             empty;
    logic             deq;
    logic             misNext;
    logic             enq;

    logic             mispredictQ;
    logic [31:0]      redirectQ;
    logic             branchMQ;
    logic             takeMQ;
    logic [31:0]      pcMQ;
    logic [CNT_W-1:0] branchCnt;
    logic [CNT_W-1:0] mispredCnt;
    logic             qErrQ;

    // A full queue may still accept a branch when the head retires in the
    // same cycle. A mispredict blocks enqueue because the D-stage branch is
    // on the wrong path.
    always_comb begin
        deq      = bus.resolve_validE & ~empty;
        misNext  = deq & (head.predTake != bus.actual_takeE);
        enq      = bus.branchD & ~bus.stallD & ~bus.flushD & (~full | deq) & ~misNext;
        newEntry = '{pc: bus.pcD, predTake: bus.pred_takeD};
    end

    branch_info_fifo #(
        .DEPTH    (QDEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (misNext),
        .push     (enq),
        .pushData (newEntry),
        .pop      (deq),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    // Resolution, predictor update and counters. Redirect, update data and
    // counters hold between events; counters stop at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredictQ <= 1'b0;
            redirectQ   <= '0;
            branchMQ    <= 1'b0;
            takeMQ      <= 1'b0;
            pcMQ        <= '0;
            branchCnt   <= '0;
            mispredCnt  <= '0;
            qErrQ       <= 1'b0;
        end else begin
            mispredictQ <= misNext;
            branchMQ    <= deq;
            if (misNext) begin
                redirectQ <= bus.actual_takeE ? bus.targetE : fallThroughPc(head.pc);
            end
            if (deq) begin
                takeMQ <= bus.actual_takeE;
                pcMQ   <= head.pc;
            end
            if (deq && (branchCnt != CNT_MAX)) begin
                branchCnt <= branchCnt + CNT_ONE;
            end
            if (misNext && (mispredCnt != CNT_MAX)) begin
                mispredCnt <= mispredCnt + CNT_ONE;
            end
            if (bus.resolve_validE && empty) begin
                qErrQ <= 1'b1;
            end
        end
    end

    assign bus.stall_req    = full & bus.branchD;
    assign bus.mispredict   = mispredictQ;
    assign bus.redirect_pc  = redirectQ;
    assign bus.branchM      = branchMQ;
    assign bus.actual_takeM = takeMQ;
    assign bus.pcM          = pcMQ;
    assign bus.branch_cnt   = branchCnt;
    assign bus.mispred_cnt  = mispredCnt;
    assign bus.q_err        = qErrQ;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Companion to the global (gshare) predictor: consumes the D-stage prediction, tracks in-flight predicted branches, and resolves them against the E-stage actual outcome. On a misprediction it issues flush and redirect. One cycle after resolution it feeds the outcome back to the predictor's M-stage update inputs (branchM, actual_takeM, pcM). It also keeps prediction-accuracy counters.

Parameters:
QDEPTH, 4, in-flight branch queue entries (power of 2, >=2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
branchD  in  1  D-stage instruction is a conditional branch
pred_takeD  in  1  predictor output for D-stage branch
pcD  in  32  PC of D-stage branch
stallD  in  1  D stage stalled; no enqueue
flushD  in  1  D stage flushed; no enqueue
resolve_validE  in  1  E-stage branch outcome valid this cycle
actual_takeE  in  1  E-stage resolved direction
targetE  in  32  E-stage computed branch target
mispredict  out  1  registered; flush younger stages this cycle
redirect_pc  out  32  registered; fetch target when mispredict=1
stall_req  out  1  queue full; stall D
branchM  out  1  registered update strobe to predictor
actual_takeM  out  1  registered outcome to predictor
pcM  out  32  registered branch PC to predictor
branch_cnt  out  CNT_W  resolved branches, saturating
mispred_cnt  out  CNT_W  mispredicted branches, saturating
q_err  out  1  sticky: resolve with empty queue

Behaviour:
- Reset: all outputs 0; queue empty; rd/wr pointers 0; counters 0; q_err 0.
- Queue: circular FIFO of {pc, pred_take}, with log2(QDEPTH)+1-bit pointers. Full when the pointer MSBs differ and the low bits are equal.
- Enqueue when branchD & ~stallD & ~flushD & ~full & ~mispredict_next.
- stall_req is combinational: it equals full & branchD.
- Dequeue (head) when resolve_validE & ~empty. Branches resolve strictly in order.
- Simultaneous enqueue and dequeue with the queue full is allowed. The count stays the same and stall_req is still raised that cycle (conservative).
- Resolution, registered one cycle: mis = head.pred_take != actual_takeE.
  - mispredict <= mis.
  - redirect_pc <= actual_takeE ? targetE : head.pc + 8 (skip the delay slot). redirect_pc holds its last value when mispredict=0.
- On mis: the queue is cleared next cycle (both pointers set to the new rd). Any same-cycle enqueue is dropped, since younger entries are wrong-path.
- Update path, latency 1: branchM <= resolve_validE & ~empty; actual_takeM <= actual_takeE; pcM <= head.pc. pcM and actual_takeM hold their value when branchM=0.
- Counters: branch_cnt += 1 on each dequeue; mispred_cnt += 1 on each mis. Both saturate at all-ones and never wrap.
- resolve_validE with an empty queue: no dequeue, no mispredict, no update; q_err <= 1 and stays set until rst.
- Reset during a pending mispredict: rst wins; the next cycle shows all outputs 0.
- 32-bit arithmetic (pc+8) wraps modulo 2^32.

Decomposition:
- Shared package/header: QDEPTH and CNT_W defaults, the delay-slot offset constant (8), and the entry field layout (pc[31:0], pred_take).
- One sub-module is natural: branch_info_fifo. It is a parameterized sync FIFO with a clear input and exposes full, empty and head.
- The top level holds the compare, redirect, update registers and counters.

Test Plan:
1. Enqueue pcD=0x00400010, pred=1; next cycle resolve take=1, target=0x00400100 -> mispredict=0; branchM=1, actual_takeM=1, pcM=0x00400010; branch_cnt=1, mispred_cnt=0.
2. Enqueue pcD=0x00400020, pred=1; resolve take=0 -> mispredict=1, redirect_pc=0x00400028, mispred_cnt=1, queue empty next cycle.
3. Enqueue pred=0; resolve take=1, targetE=0x00400200 -> mispredict=1, redirect_pc=0x00400200.
4. Enqueue 4 branches with no resolve, then assert branchD -> stall_req=1, no 5th entry. Resolve 4 in order -> pcM sequence matches enqueue order.
5. Enqueue 3 entries; mispredict on the first, with a same-cycle enqueue -> later resolve_validE gives q_err=1, branchM stays 0.
6. Preload counters to all-ones via a long run or a force, then resolve once more -> branch_cnt stays 0xFFFFFFFF. Assert rst mid-mispredict -> all outputs 0 next cycle.
